// File: rtl/seg7_scanner_pkg.sv
// Shared types and the hex-to-segment table for the four-digit seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scanner_if.sv
// Frame inputs and display pin outputs of the scanner, bundled for the host (master)
// and the scanner itself (slave).
interface seg7_scanner_if import seg7_pkg::*; ();

  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  anode;
  seg_t        segments;
  logic        dp_n;
  logic [1:0]  digit_idx;

  modport master (
    output enable, digits, dp, blank_lz,
    input  anode, segments, dp_n, digit_idx
  );

  modport slave (
    input  enable, digits, dp, blank_lz,
    output anode, segments, dp_n, digit_idx
  );

endinterface

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg7 import seg7_pkg::*; (
  input  nibble_t nibble,
  output seg_t    seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit common-anode display scanner: prescaled digit rotation, per-frame
// snapshot of the input digits, leading-zero blanking and registered pin drivers.
module seg7_scanner import seg7_pkg::*; #(
  parameter int REFRESH_DIV = 4
) (
  input logic          clock,
  input logic          reset,
  seg7_scanner_if.slave bus
);

  localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   snapshot;
  logic [3:0]    snapshot_dp;

  logic          tick;
  logic          load;
  logic [15:0]   frame;
  logic [3:0]    frame_dp;
  logic [3:0]    lz_blank;
  nibble_t       cur_digit;
  seg_t          cur_seg;

  assign tick = bus.enable && (prescaler == PRE_MAX);
  assign load = bus.enable && (idx == 2'd0) && (prescaler == '0);

  // In the load cycle the live inputs bypass the snapshot so digit 0 is never stale.
  assign frame    = load ? bus.digits : snapshot;
  assign frame_dp = load ? bus.dp     : snapshot_dp;

  always_comb begin
    lz_blank = '0;
    if (bus.blank_lz) begin
      lz_blank[3] = (frame[15:12] == 4'd0);
      lz_blank[2] = lz_blank[3] && (frame[11:8] == 4'd0);
      lz_blank[1] = lz_blank[2] && (frame[7:4] == 4'd0);
    end
  end

  assign cur_digit = frame[{idx, 2'b00} +: 4];

  hex_to_seg7 u_decode (
    .nibble (cur_digit),
    .seg    (cur_seg)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler    <= '0;
      idx          <= 2'd0;
      snapshot     <= '0;
      snapshot_dp  <= '0;
      bus.anode    <= 4'b1111;
      bus.segments <= SEG_BLANK;
      bus.dp_n     <= 1'b1;
    end else if (bus.enable) begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (load) begin
        snapshot    <= bus.digits;
        snapshot_dp <= bus.dp;
      end
      bus.anode    <= ~(4'b0001 << idx);
      bus.segments <= lz_blank[idx] ? SEG_BLANK : cur_seg;
      bus.dp_n     <= ~frame_dp[idx];
    end else begin
      // Disabled: scan state holds, pins go dark.
      bus.anode    <= 4'b1111;
      bus.segments <= SEG_BLANK;
      bus.dp_n     <= 1'b1;
    end
  end

  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner: directed scenarios plus random traffic, all
// checked against a model that tracks elapsed enabled cycles since reset.
module tb_seg7_scanner;

  localparam int DIV = 4;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  // Reference model state: number of enabled cycles since the last reset.
  int          act_cnt;
  logic [15:0] m_snap;
  logic [3:0]  m_snap_dp;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;
  logic        exp_dpn;
  logic [1:0]  exp_idx;

  seg7_scanner_if bus ();

  seg7_scanner #(.REFRESH_DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // One clock edge; the model derives position from the enabled-cycle count.
  task automatic clock_step();
    int          pos;
    logic [15:0] f;
    logic [3:0]  fdp;
    @(posedge clock);
    if (!reset) begin
      act_cnt = 0; m_snap = '0; m_snap_dp = '0;
      exp_anode = 4'b1111; exp_seg = 7'h7F; exp_dpn = 1'b1;
    end else if (!bus.enable) begin
      exp_anode = 4'b1111; exp_seg = 7'h7F; exp_dpn = 1'b1;
    end else begin
      pos = (act_cnt / DIV) % 4;
      if (act_cnt % (4 * DIV) == 0) begin
        f = bus.digits; fdp = bus.dp;
        m_snap = bus.digits; m_snap_dp = bus.dp;
      end else begin
        f = m_snap; fdp = m_snap_dp;
      end
      exp_anode = ~(4'b0001 << pos);
      if (bus.blank_lz && pos > 0 && (f >> (4 * pos)) == 16'd0)
        exp_seg = 7'h7F;
      else
        exp_seg = ref_seg(4'((f >> (4 * pos)) & 16'hF));
      exp_dpn = ~fdp[pos];
      act_cnt++;
    end
    exp_idx = 2'((act_cnt / DIV) % 4);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clock_step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1'b0;
      bus.enable = 1'($urandom); bus.digits = 16'($urandom);
      bus.dp = 4'($urandom); bus.blank_lz = 1'($urandom);
      clock_step();
      total += 4;
      if (bus.anode !== 4'b1111) begin bad++; $display("FAIL reset_anode: got %b want 1111", bus.anode); end
      if (bus.segments !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", bus.segments); end
      if (bus.dp_n !== 1'b1) begin bad++; $display("FAIL reset_dpn: got %b want 1", bus.dp_n); end
      if (bus.digit_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.digit_idx); end
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_scan();
    logic [6:0] want_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    bus.enable = 1'b1; bus.digits = 16'h1234; bus.dp = 4'h0; bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      clock_step();
      total += 6;
      if (bus.anode !== exp_anode) begin bad++; $display("FAIL scan_anode[%0d]: got %b want %b", i, bus.anode, exp_anode); end
      if (bus.segments !== exp_seg) begin bad++; $display("FAIL scan_seg[%0d]: got %h want %h", i, bus.segments, exp_seg); end
      if (bus.dp_n !== exp_dpn) begin bad++; $display("FAIL scan_dpn[%0d]: got %b want %b", i, bus.dp_n, exp_dpn); end
      if (bus.digit_idx !== exp_idx) begin bad++; $display("FAIL scan_idx[%0d]: got %0d want %0d", i, bus.digit_idx, exp_idx); end
      if (bus.anode !== ~(4'b0001 << ((i / 4) % 4))) begin bad++; $display("FAIL scan_walk[%0d]: got %b", i, bus.anode); end
      if (bus.segments !== want_seg[(i / 4) % 4]) begin bad++; $display("FAIL scan_pattern[%0d]: got %h want %h", i, bus.segments, want_seg[(i / 4) % 4]); end
    end
  endtask

  task automatic test_tear_free();
    bus.enable = 1'b1; bus.digits = 16'h1234; bus.dp = 4'h0; bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i == 5) bus.digits = 16'hABCD;
      clock_step();
      total += 2;
      if (bus.segments !== exp_seg) begin bad++; $display("FAIL tear_seg[%0d]: got %h want %h", i, bus.segments, exp_seg); end
      if (bus.anode !== exp_anode) begin bad++; $display("FAIL tear_anode[%0d]: got %b want %b", i, bus.anode, exp_anode); end
      if (i == 12) begin
        total++;
        if (bus.segments !== 7'h79) begin bad++; $display("FAIL tear_old_frame: got %h want 79", bus.segments); end
      end
      if (i == 16) begin
        total++;
        if (bus.segments !== 7'h21) begin bad++; $display("FAIL tear_new_frame: got %h want 21", bus.segments); end
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] pats [2] = '{16'h0050, 16'h0000};
    bus.enable = 1'b1; bus.dp = 4'h0; bus.blank_lz = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.digits = pats[p];
      do_reset();
      for (int i = 0; i < 16; i++) begin
        clock_step();
        total += 2;
        if (bus.segments !== exp_seg) begin bad++; $display("FAIL lz_seg[%0d/%0d]: got %h want %h", p, i, bus.segments, exp_seg); end
        if (bus.anode !== exp_anode) begin bad++; $display("FAIL lz_anode[%0d/%0d]: got %b want %b", p, i, bus.anode, exp_anode); end
        if (p == 0 && i == 4) begin
          total++;
          if (bus.segments !== 7'h12) begin bad++; $display("FAIL lz_digit1: got %h want 12", bus.segments); end
        end
        if (i == 12) begin
          total++;
          if (bus.segments !== 7'h7F) begin bad++; $display("FAIL lz_digit3: got %h want 7f", bus.segments); end
        end
        if (i == 0) begin
          total++;
          if (bus.segments !== 7'h40) begin bad++; $display("FAIL lz_digit0: got %h want 40", bus.segments); end
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    bus.enable = 1'b1; bus.digits = 16'($urandom); bus.dp = 4'($urandom); bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) clock_step();
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clock_step();
      total += 3;
      if (bus.anode !== 4'b1111) begin bad++; $display("FAIL gate_anode[%0d]: got %b want 1111", i, bus.anode); end
      if (bus.digit_idx !== 2'd2) begin bad++; $display("FAIL gate_idx[%0d]: got %0d want 2", i, bus.digit_idx); end
      if (bus.segments !== exp_seg) begin bad++; $display("FAIL gate_seg[%0d]: got %h want %h", i, bus.segments, exp_seg); end
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      clock_step();
      total += 3;
      if (bus.anode !== exp_anode) begin bad++; $display("FAIL regate_anode[%0d]: got %b want %b", i, bus.anode, exp_anode); end
      if (bus.segments !== exp_seg) begin bad++; $display("FAIL regate_seg[%0d]: got %h want %h", i, bus.segments, exp_seg); end
      if (bus.digit_idx !== exp_idx) begin bad++; $display("FAIL regate_idx[%0d]: got %0d want %0d", i, bus.digit_idx, exp_idx); end
      if (i == 0 || i == 1) begin
        total++;
        if (bus.anode !== 4'b1011) begin bad++; $display("FAIL regate_resume[%0d]: got %b want 1011", i, bus.anode); end
      end
    end
  endtask

  task automatic test_reset_dp();
    bus.enable = 1'b1; bus.digits = 16'($urandom); bus.dp = 4'b0100; bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      clock_step();
      total += 2;
      if (bus.dp_n !== (bus.anode !== 4'b1011)) begin bad++; $display("FAIL dp_track[%0d]: dp_n=%b anode=%b", i, bus.dp_n, bus.anode); end
      if (bus.dp_n !== exp_dpn) begin bad++; $display("FAIL dp_model[%0d]: got %b want %b", i, bus.dp_n, exp_dpn); end
    end
    total++;
    if (bus.digit_idx !== 2'd3) begin bad++; $display("FAIL midreset_pre_idx: got %0d want 3", bus.digit_idx); end
    bus.digits = 16'h8765;
    reset = 1'b0;
    clock_step();
    total += 3;
    if (bus.anode !== 4'b1111) begin bad++; $display("FAIL midreset_anode: got %b want 1111", bus.anode); end
    if (bus.digit_idx !== 2'd0) begin bad++; $display("FAIL midreset_idx: got %0d want 0", bus.digit_idx); end
    if (bus.segments !== 7'h7F) begin bad++; $display("FAIL midreset_seg: got %h want 7f", bus.segments); end
    reset = 1'b1;
    clock_step();
    total += 2;
    if (bus.anode !== 4'b1110) begin bad++; $display("FAIL restart_anode: got %b want 1110", bus.anode); end
    if (bus.segments !== 7'h12) begin bad++; $display("FAIL restart_seg: got %h want 12", bus.segments); end
  endtask

  task automatic test_random();
    bus.enable = 1'b1; bus.blank_lz = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(99) >= 2);
      bus.enable = ($urandom_range(99) >= 15);
      if ($urandom_range(9) == 0) bus.digits = ($urandom_range(1) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      if ($urandom_range(9) == 0) bus.dp = 4'($urandom);
      if ($urandom_range(19) == 0) bus.blank_lz = ~bus.blank_lz;
      clock_step();
      total += 4;
      if (bus.anode !== exp_anode) begin bad++; $display("FAIL rand_anode[%0d]: got %b want %b", i, bus.anode, exp_anode); end
      if (bus.segments !== exp_seg) begin bad++; $display("FAIL rand_seg[%0d]: got %h want %h", i, bus.segments, exp_seg); end
      if (bus.dp_n !== exp_dpn) begin bad++; $display("FAIL rand_dpn[%0d]: got %b want %b", i, bus.dp_n, exp_dpn); end
      if (bus.digit_idx !== exp_idx) begin bad++; $display("FAIL rand_idx[%0d]: got %0d want %0d", i, bus.digit_idx, exp_idx); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    act_cnt = 0; m_snap = '0; m_snap_dp = '0;
    exp_anode = 4'b1111; exp_seg = 7'h7F; exp_dpn = 1'b1; exp_idx = 2'd0;
    reset = 1'b0;
    bus.enable = 1'b0; bus.digits = '0; bus.dp = '0; bus.blank_lz = 1'b0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_blanking();
    test_enable_gating();
    test_reset_dp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
